// File: rtl/tcam_pkg.sv
// rtl/tcam_pkg.sv - shared defaults, width helpers and arbiter state encoding
package tcam_pkg;

  localparam int DEF_KEY_W   = 128;
  localparam int DEF_ENTRIES = 16;
  localparam int DEF_NREQ    = 4;
  localparam int DEF_LAT     = 2;

  // Entry index width; a single-entry TCAM still gets a 1-bit index
  function automatic int idx_width(input int entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

  // Requester id width; a single requester still gets a 1-bit id
  function automatic int id_width(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    DRAIN = 2'd1,
    WRITE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - NREQ-wide round-robin one-hot grant with pointer advance on grant
module rr_arbiter
  import tcam_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int ID_W = id_width(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en_i,
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [ID_W-1:0] gnt_id_o,
  output logic            gnt_valid_o
);

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic            found;

  // Pick the first active requester at or after the pointer, wrapping modulo NREQ
  always_comb begin
    gnt_o    = '0;
    gnt_id_o = '0;
    found    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (en_i && !found && req_i[i] && (i == (int'(ptr_q) + k) % NREQ)) begin
          gnt_o[i] = 1'b1;
          gnt_id_o = ID_W'(i);
          found    = 1'b1;
        end
      end
    end
  end

  assign gnt_valid_o = found;

  // Pointer moves just past the winner so it has lowest priority next time
  always_comb begin
    ptr_d = ptr_q;
    if (found) begin
      ptr_d = (int'(gnt_id_o) == NREQ - 1) ? '0 : ID_W'(int'(gnt_id_o) + 1);
    end
  end

  // Pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/tcam_lookup_arbiter.sv
// rtl/tcam_lookup_arbiter.sv - shares one TCAM between lookup requesters and an entry-write port
module tcam_lookup_arbiter
  import tcam_pkg::*;
#(
  parameter int KEY_W   = DEF_KEY_W,
  parameter int ENTRIES = DEF_ENTRIES,
  parameter int NREQ    = DEF_NREQ,
  parameter int LAT     = DEF_LAT,
  parameter int IDX_W   = idx_width(ENTRIES),
  parameter int ID_W    = id_width(NREQ)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*KEY_W-1:0] req_key,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  cfg_wr_valid,
  input  logic                  cfg_wr_is_mask,
  input  logic [IDX_W-1:0]      cfg_wr_addr,
  input  logic [KEY_W-1:0]      cfg_wr_data,
  output logic                  cfg_wr_ready,
  output logic                  rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  rsp_hit,
  output logic [IDX_W-1:0]      rsp_index,
  output logic [KEY_W-1:0]      tcam_key,
  output logic                  tcam_key_valid,
  output logic                  tcam_wr_en,
  output logic                  tcam_wr_is_mask,
  output logic [IDX_W-1:0]      tcam_wr_addr,
  output logic [KEY_W-1:0]      tcam_wr_data,
  input  logic                  tcam_hit,
  input  logic [IDX_W-1:0]      tcam_hit_index
);

  arb_state_e state_q, state_d;
  logic       arb_en;
  logic       wr_take;

  logic [NREQ-1:0]  gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_valid;
  logic [KEY_W-1:0] key_sel;

  // Tag pipe: stage LAT lines up with tcam_hit for the lookup it describes
  logic [LAT:0]    tag_v_q;
  logic [ID_W-1:0] tag_id_q [LAT+1];

  logic [KEY_W-1:0] key_q;
  logic             key_valid_q;
  logic             wr_en_q;
  logic             wr_is_mask_q;
  logic [IDX_W-1:0] wr_addr_q;
  logic [KEY_W-1:0] wr_data_q;
  logic             rsp_valid_q;
  logic [ID_W-1:0]  rsp_id_q;
  logic             rsp_hit_q;
  logic [IDX_W-1:0] rsp_index_q;

  rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_rr (
    .clk         (clk),
    .rst_n       (resetn),
    .en_i        (arb_en),
    .req_i       (req_valid),
    .gnt_o       (gnt),
    .gnt_id_o    (gnt_id),
    .gnt_valid_o (gnt_valid)
  );

  // Writes take priority: stop granting, wait for the pipe to empty, then write once
  always_comb begin
    state_d = state_q;
    arb_en  = 1'b0;
    wr_take = 1'b0;
    case (state_q)
      ARB: begin
        if (cfg_wr_valid) state_d = DRAIN;
        else              arb_en  = 1'b1;
      end
      DRAIN: begin
        if (tag_v_q == '0) state_d = WRITE;
      end
      WRITE: begin
        wr_take = 1'b1;
        state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  // Key of the granted requester
  always_comb begin
    key_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) key_sel = req_key[i*KEY_W +: KEY_W];
    end
  end

  // Handshake signals are forced low while reset is held
  assign req_ready    = gnt & {NREQ{resetn}};
  assign cfg_wr_ready = wr_take & resetn;

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ARB;
    else         state_q <= state_d;
  end

  // Lookup issue: key and strobe go out the cycle after the grant
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      key_q       <= '0;
      key_valid_q <= 1'b0;
    end else begin
      key_valid_q <= gnt_valid;
      if (gnt_valid) key_q <= key_sel;
    end
  end

  // Entry write: sampled in WRITE, presented to the TCAM for one cycle after
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_en_q      <= 1'b0;
      wr_is_mask_q <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      wr_en_q <= wr_take;
      if (wr_take) begin
        wr_is_mask_q <= cfg_wr_is_mask;
        wr_addr_q    <= cfg_wr_addr;
        wr_data_q    <= cfg_wr_data;
      end
    end
  end

  // Tag pipe shift; reset discards every in-flight lookup
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tag_v_q <= '0;
      for (int i = 0; i <= LAT; i++) tag_id_q[i] <= '0;
    end else begin
      tag_v_q     <= {tag_v_q[LAT-1:0], gnt_valid};
      tag_id_q[0] <= gnt_id;
      for (int i = 1; i <= LAT; i++) tag_id_q[i] <= tag_id_q[i-1];
    end
  end

  // Response register, loaded when the tag pipe output meets the TCAM result
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_index_q <= '0;
    end else begin
      rsp_valid_q <= tag_v_q[LAT];
      if (tag_v_q[LAT]) begin
        rsp_id_q    <= tag_id_q[LAT];
        rsp_hit_q   <= tcam_hit;
        rsp_index_q <= tcam_hit_index;
      end
    end
  end

  assign tcam_key        = key_q;
  assign tcam_key_valid  = key_valid_q;
  assign tcam_wr_en      = wr_en_q;
  assign tcam_wr_is_mask = wr_is_mask_q;
  assign tcam_wr_addr    = wr_addr_q;
  assign tcam_wr_data    = wr_data_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_id          = rsp_id_q;
  assign rsp_hit         = rsp_hit_q;
  assign rsp_index       = rsp_index_q;

endmodule
